// File: rtl/bpf_defs_pkg.sv
// bpf_defs: shared code/instruction widths and the {instr, pc} fetch-entry type
package bpf_defs;
  localparam int CODE_ADDR_WIDTH = 10;
  localparam int INSTR_WIDTH = 64;
  typedef struct packed {
    logic [INSTR_WIDTH-1:0]     instr;
    logic [CODE_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: 2-entry FIFO of fetch entries; in: push_i/pop_i/flush_i/data_i, out: registered head data_o, occ_o, empty_o
module fetch_queue
  import bpf_defs::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  fetch_entry_t data_i,
  output fetch_entry_t data_o,
  output logic [1:0]   occ_o,
  output logic         empty_o
);
  fetch_entry_t head_q, head_d, tail_q, tail_d;
  logic [1:0] occ_q, occ_d;
  always_comb begin
    occ_d  = flush_i ? 2'd0 : occ_q + {1'b0, push_i} - {1'b0, pop_i};
    head_d = (pop_i && occ_q == 2'd2) ? tail_q :
             (push_i && occ_q == (pop_i ? 2'd1 : 2'd0)) ? data_i : head_q;
    tail_d = (push_i && occ_q == (pop_i ? 2'd2 : 2'd1)) ? data_i : tail_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
    end
  end
  assign data_o  = head_q;
  assign occ_o   = occ_q;
  assign empty_o = occ_q == 2'd0;
endmodule

// File: rtl/stage0_fetch.sv
// stage0_fetch: PC/issue logic driving code memory, 2-entry return queue, valid/ready output with mispredict flush
module stage0_fetch
  import bpf_defs::*;
#(
  parameter int CODE_ADDR_WIDTH = bpf_defs::CODE_ADDR_WIDTH,
  parameter int INSTR_WIDTH     = bpf_defs::INSTR_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cpu_en,
  output logic [CODE_ADDR_WIDTH-1:0] code_mem_rd_addr,
  output logic                       code_mem_rd_en,
  input  logic [INSTR_WIDTH-1:0]     code_mem_rd_data,
  input  logic                       branch_mispredict,
  input  logic [CODE_ADDR_WIDTH-1:0] branch_target,
  output logic [INSTR_WIDTH-1:0]     instr_out,
  output logic [CODE_ADDR_WIDTH-1:0] pc_out,
  output logic                       vld,
  input  logic                       next_rdy
);
  fetch_entry_t head, push_data;
  logic [1:0] occ, cnt;
  logic empty, pop, issue, inflight_q, inflight_d;
  logic [CODE_ADDR_WIDTH-1:0] pc_q, pc_d, issued_pc_q, issued_pc_d;
  always_comb begin
    pop         = vld && next_rdy;
    cnt         = occ + {1'b0, inflight_q} - {1'b0, pop};
    issue       = !rst && cpu_en && !branch_mispredict && cnt < 2'd2;
    pc_d        = branch_mispredict ? branch_target : issue ? pc_q + CODE_ADDR_WIDTH'(1) : pc_q;
    inflight_d  = issue;
    issued_pc_d = issue ? pc_q : issued_pc_q;
    push_data   = '{instr: code_mem_rd_data, pc: issued_pc_q};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q        <= '0;
      issued_pc_q <= '0;
      inflight_q  <= 1'b0;
    end else begin
      pc_q        <= pc_d;
      issued_pc_q <= issued_pc_d;
      inflight_q  <= inflight_d;
    end
  end
  fetch_queue u_queue (
    .clk     (clk),
    .rst     (rst),
    .push_i  (inflight_q && !branch_mispredict),
    .pop_i   (pop && !branch_mispredict),
    .flush_i (branch_mispredict),
    .data_i  (push_data),
    .data_o  (head),
    .occ_o   (occ),
    .empty_o (empty)
  );
  assign vld              = !empty;
  assign instr_out        = head.instr;
  assign pc_out           = head.pc;
  assign code_mem_rd_en   = issue;
  assign code_mem_rd_addr = pc_q;
endmodule

// File: tb/tb_stage0_fetch.sv
// tb_stage0_fetch: directed stimulus with expected-PC scoreboard checked by an output monitor
module tb_stage0_fetch;
  logic clk = 1'b0, rst = 1'b1, cpu_en = 1'b0, branch_mispredict = 1'b0, next_rdy = 1'b0;
  logic [9:0] branch_target = '0;
  logic [9:0] code_mem_rd_addr, pc_out;
  logic code_mem_rd_en, vld;
  logic [63:0] code_mem_rd_data = '0, instr_out;
  logic [9:0] exp_q[$];
  logic [9:0] wrap_addr[4] = '{10'd1022, 10'd1023, 10'd0, 10'd1};
  int n_cmp = 0, n_err = 0;
  stage0_fetch dut (
    .clk               (clk),
    .rst               (rst),
    .cpu_en            (cpu_en),
    .code_mem_rd_addr  (code_mem_rd_addr),
    .code_mem_rd_en    (code_mem_rd_en),
    .code_mem_rd_data  (code_mem_rd_data),
    .branch_mispredict (branch_mispredict),
    .branch_target     (branch_target),
    .instr_out         (instr_out),
    .pc_out            (pc_out),
    .vld               (vld),
    .next_rdy          (next_rdy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) code_mem_rd_data <= code_mem_rd_en ? 64'h1000 + 64'(code_mem_rd_addr) : 64'hBAD0_0000_0000_0000;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic cyc(input logic en, input logic rdy, input logic mis = 1'b0, input logic [9:0] tgt = '0);
    @(posedge clk);
    #1;
    cpu_en = en;
    next_rdy = rdy;
    branch_mispredict = mis;
    branch_target = tgt;
    @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!rst && vld && next_rdy) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_pop: got pc %0d want none", pc_out);
      end else begin
        automatic logic [9:0] p = exp_q.pop_front();
        chk("pop_pc", 64'(pc_out), 64'(p));
        chk("pop_instr", instr_out, 64'h1000 + 64'(p));
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end
  initial begin
    @(negedge clk);
    chk("rst_vld", 64'(vld), 0);
    chk("rst_rd_en", 64'(code_mem_rd_en), 0);
    chk("rst_addr", 64'(code_mem_rd_addr), 0);
    chk("rst_instr", instr_out, 0);
    chk("rst_pc", 64'(pc_out), 0);
    for (int k = 0; k <= 12; k++) exp_q.push_back(10'(k));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cpu_en = 1'b1;
    next_rdy = 1'b1;
    @(negedge clk);
    chk("first_rd_en", 64'(code_mem_rd_en), 1);
    chk("first_addr", 64'(code_mem_rd_addr), 0);
    chk("lat_vld_c0", 64'(vld), 0);
    cyc(1, 1);
    chk("lat_vld_c1", 64'(vld), 0);
    cyc(1, 1);
    chk("lat_vld_c2", 64'(vld), 1);
    repeat (7) cyc(1, 1);
    for (int k = 0; k < 5; k++) begin
      cyc(1, 0);
      chk("stall_rd_en", 64'(code_mem_rd_en), 0);
      chk("stall_vld", 64'(vld), 1);
      chk("stall_pc", 64'(pc_out), 8);
    end
    cyc(1, 1);
    chk("release_rd_en", 64'(code_mem_rd_en), 1);
    chk("release_addr", 64'(code_mem_rd_addr), 10);
    repeat (4) cyc(1, 1);
    exp_q.push_back(10'd200);
    exp_q.push_back(10'd201);
    cyc(1, 0, 1, 10'd200);
    chk("mis_rd_en", 64'(code_mem_rd_en), 0);
    cyc(1, 1);
    chk("redir_vld1", 64'(vld), 0);
    chk("redir_rd_en", 64'(code_mem_rd_en), 1);
    chk("redir_addr", 64'(code_mem_rd_addr), 200);
    cyc(1, 1);
    chk("redir_vld2", 64'(vld), 0);
    cyc(1, 1);
    chk("redir_vld3", 64'(vld), 1);
    cyc(1, 1);
    for (int k = 0; k < 4; k++) exp_q.push_back(wrap_addr[k]);
    cyc(1, 0, 1, 10'd1022);
    for (int k = 0; k < 4; k++) begin
      cyc(1, 1);
      chk("wrap_rd_en", 64'(code_mem_rd_en), 1);
      chk("wrap_addr", 64'(code_mem_rd_addr), 64'(wrap_addr[k]));
    end
    for (int k = 0; k < 4; k++) begin
      cyc(0, 1);
      chk("en_off_rd_en", 64'(code_mem_rd_en), 0);
    end
    chk("en_off_drained", 64'(exp_q.size()), 0);
    cyc(1, 1);
    chk("resume_rd_en", 64'(code_mem_rd_en), 1);
    chk("resume_addr", 64'(code_mem_rd_addr), 2);
    cyc(1, 1);
    @(posedge clk);
    #2;
    chk("pre_rst_vld", 64'(vld), 1);
    chk("pre_rst_pc", 64'(pc_out), 2);
    chk("pre_rst_rd_en", 64'(code_mem_rd_en), 1);
    chk("pre_rst_addr", 64'(code_mem_rd_addr), 4);
    #1;
    rst = 1'b1;
    #1;
    chk("async_vld", 64'(vld), 0);
    chk("async_rd_en", 64'(code_mem_rd_en), 0);
    chk("async_addr", 64'(code_mem_rd_addr), 0);
    chk("async_pc", 64'(pc_out), 0);
    chk("async_instr", instr_out, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_rd_en", 64'(code_mem_rd_en), 1);
    chk("post_rst_addr", 64'(code_mem_rd_addr), 0);
    chk("post_rst_vld", 64'(vld), 0);
    for (int k = 0; k < 4; k++) exp_q.push_back(10'(k));
    repeat (3) cyc(1, 1);
    repeat (4) cyc(0, 1);
    chk("final_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/stage0_fetch.md
# stage0_fetch

Instruction fetch stage of the BPF CPU pipeline, directly upstream of the stage0.5 timing-isolation buffer. Owns the program counter and drives the code memory's read port, which has one cycle of read latency. Buffers the returned 64-bit instructions in a 2-entry queue so that back-pressure never loses data. Each instruction is presented downstream together with its PC, under a valid/ready handshake. On a branch mispredict it redirects to a new PC and discards all wrong-path work.

## Interface
- CODE_ADDR_WIDTH, 10, code memory word-address width; also the PC width.
- INSTR_WIDTH, 64, instruction word width.
- clk  in  1  sole clock; everything is sampled on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- cpu_en  in  1  fetch enable; when low, no new reads are issued.
- code_mem_rd_addr  out  CODE_ADDR_WIDTH  read address to code memory.
- code_mem_rd_en  out  1  read strobe; data returns the following cycle.
- code_mem_rd_data  in  INSTR_WIDTH  read data, valid the cycle after rd_en.
- branch_mispredict  in  1  flush request from downstream.
- branch_target  in  CODE_ADDR_WIDTH  new PC; used when branch_mispredict=1.
- instr_out  out  INSTR_WIDTH  instruction at the queue head.
- pc_out  out  CODE_ADDR_WIDTH  PC of instr_out.
- vld  out  1  instr_out and pc_out are valid.
- next_rdy  in  1  downstream can accept this cycle.

## Operation
- **Reset values:** pc=0, queue empty, inflight=0, vld=0, code_mem_rd_en=0, code_mem_rd_addr=0, instr_out=0, pc_out=0.
- **Transfer:** a transfer (pop) occurs when vld && next_rdy.
- **Credit count:** cnt = occupancy + inflight − pop. Range is 0..2.
- **Issue** is a combinational decision made in cycle N, when cpu_en && !branch_mispredict && cnt<2. When it issues:
  - code_mem_rd_en=1 and code_mem_rd_addr=pc in cycle N.
  - At the end of N: pc <= pc+1, taken modulo 2^CODE_ADDR_WIDTH (1023 wraps to 0); inflight <= 1.
- **Return:** in cycle N+1, if inflight is set, {code_mem_rd_data, issued pc} is pushed into the queue. The issued pc is held in a register captured at issue.
- **Capacity:** the queue never overflows by construction, because cnt<2 gates issue. A push and a pop in the same cycle are both performed.
- **Mispredict (cycle M):**
  - Queue is cleared and inflight is cleared.
  - Any code_mem_rd_data returning in M+1 is discarded.
  - pc <= branch_target.
  - No issue happens in cycle M.
  - It overrides any same-cycle pop or push.
  - It acts identically whether cpu_en is high or low.
- **cpu_en low:** in-flight data still lands in the queue, and queued data still drains. Only new issue stops.
- **Ownership:** the PC is owned here; branch_target comes from the executing stage.

## Timing
- **Issue-to-output latency:** issue in cycle N gives vld=1 with that instruction in N+2.
- **Throughput:** one instruction per cycle when next_rdy is held high.
- **Back-pressure:** with next_rdy low, at most 2 instructions are held. Issue stops once cnt=2. When next_rdy returns high, a pop and a new issue happen in that same cycle.
- **Redirect:** after a mispredict in cycle M, the target is issued in M+1 and the target's instruction has vld=1 in M+3. vld is 0 in M+1 and M+2.
- **Output stability:** while vld && !next_rdy, instr_out and pc_out are stable.
- **Reset:** asynchronous assertion mid-operation forces all reset values immediately. After deassertion, the first issue is in the first cycle with cpu_en=1, at address 0.

## Structure
- **Shared package `bpf_defs`:**
  - CODE_ADDR_WIDTH default
  - INSTR_WIDTH=64
  - a fetch-entry struct {instr, pc}
- **Sub-module `fetch_queue`:** 2-entry synchronous FIFO.
  - Ports: push, pop, flush, data, occupancy, empty.
  - Asynchronous reset.
  - Head is presented on a registered read.
- **Top level:** PC register, inflight flag, issued-pc register, credit/issue logic.

## Test plan
- **Streaming:** reset, then cpu_en=1, next_rdy=1, memory returns word k = 64'h1000+k. Required: vld rises 2 cycles after the first rd_en; outputs are pc_out=0,1,2,… with instr_out=64'h1000,…, one per cycle and none skipped.
- **Stall:** hold next_rdy=0 for 5 cycles mid-stream. Required: exactly 2 entries held; rd_en is low during the stall after the credit fills; on release, order continues with no gap or duplicate.
- **Mispredict with data in flight:** pulse branch_mispredict with branch_target=200 while an instruction is in flight and the queue holds 1. Required: vld=0 for 2 cycles; the next output is pc_out=200; the wrong-path word is never presented.
- **PC wrap:** start at pc=1022 via mispredict. Required: issued addresses are 1022, 1023, 0, 1.
- **cpu_en drop, then reset:** drop cpu_en with 1 instruction in flight. Required: it still arrives and drains, and no further rd_en is issued. Then assert rst asynchronously mid-cycle. Required: vld and rd_en go to 0 immediately, and after release the first fetch is from 0.
